ls_usb_tx: RTL and testbench

- Low-speed USB transmit serializer. Sits directly downstream of the packet-ROM/control core.
- Consumes its byte stream (sbyte, start_pkt, last_pkt_byte) and returns show_next to advance its byte pointer.
- Byte 0 of every stream is the SYNC byte (0x80), so this block does no SYNC generation of its own.
- Performs LSB-first serialization, bit stuffing, NRZI encoding and EOP generation, and drives the D+/D- pad pair with output enable.

---
 rtl/ls_usb_tx.sv | 206 ++++++++++++++++++++
 tb/tb_ls_usb_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ls_usb_tx.sv
// ls_usb_tx: low-speed USB transmit serializer.
// Takes the byte stream from the packet core, SYNC included as byte 0.
// Serializes LSB first, inserts stuff bits, NRZI-encodes, appends the EOP and
// drives the D+/D- pad pair.
// Optional macro LS_TX_TURNAROUND_EN adds TURNAROUND_BITS idle-J bit periods
// before SYNC, with the pad still released.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   sbyte          current byte from the core
//   start_pkt      pulse: byte 0 is on sbyte
//   last_pkt_byte  the byte on sbyte is the last of the packet
//   show_next      pulse: core advances its byte pointer
//   dp, dm, oe     pad drive values and output enable
//   busy           high from start acceptance until the EOP completes
module ls_usb_tx #(
    parameter int unsigned CLK_PER_BIT     = 8,
    parameter int unsigned TURNAROUND_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sbyte,
    input  logic       start_pkt,
    input  logic       last_pkt_byte,
    output logic       show_next,
    output logic       dp,
    output logic       dm,
    output logic       oe,
    output logic       busy
);
    localparam int unsigned BW = $clog2(CLK_PER_BIT);
    localparam int unsigned CW = (TURNAROUND_BITS > 2) ? $clog2(TURNAROUND_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_EOP_SE0,
        S_EOP_J
`ifdef LS_TX_TURNAROUND_EN
        , S_TURN
`endif
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          last, last_n;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [2:0]    ones, ones_n;
    logic          dp_n, dm_n, oe_n, busy_n, show_next_n;
    logic          tx_bit;
    logic          bit_end;

    assign bit_end = (bcnt == BW'(CLK_PER_BIT - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bcnt      <= '0;
            cnt       <= '0;
            shreg     <= '0;
            last      <= 1'b0;
            bit_idx   <= '0;
            ones      <= '0;
            dp        <= 1'b0;
            dm        <= 1'b1;
            oe        <= 1'b0;
            busy      <= 1'b0;
            show_next <= 1'b0;
        end else begin
            state     <= state_n;
            bcnt      <= bcnt_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            last      <= last_n;
            bit_idx   <= bit_idx_n;
            ones      <= ones_n;
            dp        <= dp_n;
            dm        <= dm_n;
            oe        <= oe_n;
            busy      <= busy_n;
            show_next <= show_next_n;
        end
    end

    // Next state; the bit sent in a period is chosen at the edge that opens it,
    // so dp/dm already show that bit during the period (dp doubles as NRZI level).
    always_comb begin
        state_n     = state;
        bcnt_n      = bit_end ? '0 : bcnt + BW'(1);
        cnt_n       = cnt;
        shreg_n     = shreg;
        last_n      = last;
        bit_idx_n   = bit_idx;
        ones_n      = ones;
        dp_n        = dp;
        dm_n        = dm;
        oe_n        = oe;
        busy_n      = busy;
        show_next_n = 1'b0;
        tx_bit      = 1'b0;

        case (state)
            S_IDLE: begin
                bcnt_n = '0;
                dp_n   = 1'b0;
                dm_n   = 1'b1;
                oe_n   = 1'b0;
                busy_n = 1'b0;
                if (start_pkt) begin
                    shreg_n     = sbyte;
                    last_n      = last_pkt_byte;
                    ones_n      = '0;
                    busy_n      = 1'b1;
                    show_next_n = ~last_pkt_byte;
`ifdef LS_TX_TURNAROUND_EN
                    state_n   = S_TURN;
                    bit_idx_n = '0;
                    cnt_n     = '0;
`else
                    // First SYNC bit goes out straight from the incoming byte.
                    state_n   = S_DATA;
                    oe_n      = 1'b1;
                    tx_bit    = sbyte[0];
                    dp_n      = tx_bit ? 1'b0 : 1'b1;
                    dm_n      = ~dp_n;
                    ones_n    = tx_bit ? 3'd1 : 3'd0;
                    bit_idx_n = 4'd1;
`endif
                end
            end
`ifdef LS_TX_TURNAROUND_EN
            S_TURN: begin
                if (bit_end) begin
                    if (cnt == CW'(TURNAROUND_BITS - 1)) begin
                        state_n   = S_DATA;
                        oe_n      = 1'b1;
                        tx_bit    = shreg[0];
                        dp_n      = tx_bit ? dp : ~dp;
                        dm_n      = ~dp_n;
                        ones_n    = tx_bit ? ones + 3'd1 : 3'd0;
                        bit_idx_n = 4'd1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
`endif
            S_DATA: begin
                if (bit_end) begin
                    if (ones == 3'd6) begin
                        // Stuff bit: forced transition, data bit held back.
                        dp_n   = ~dp;
                        dm_n   = dp;
                        ones_n = '0;
                    end else if (bit_idx == 4'd8) begin
                        if (!last) begin
                            // Reload and send bit 0 of the next byte with no gap.
                            shreg_n     = sbyte;
                            last_n      = last_pkt_byte;
                            show_next_n = ~last_pkt_byte;
                            tx_bit      = sbyte[0];
                            dp_n        = tx_bit ? dp : ~dp;
                            dm_n        = ~dp_n;
                            ones_n      = tx_bit ? ones + 3'd1 : 3'd0;
                            bit_idx_n   = 4'd1;
                        end else begin
                            state_n = S_EOP_SE0;
                            dp_n    = 1'b0;
                            dm_n    = 1'b0;
                            cnt_n   = '0;
                        end
                    end else begin
                        tx_bit    = shreg[bit_idx[2:0]];
                        dp_n      = tx_bit ? dp : ~dp;
                        dm_n      = ~dp_n;
                        ones_n    = tx_bit ? ones + 3'd1 : 3'd0;
                        bit_idx_n = bit_idx + 4'd1;
                    end
                end
            end
            S_EOP_SE0: begin
                if (bit_end) begin
                    if (cnt == CW'(1)) begin
                        state_n = S_EOP_J;
                        dp_n    = 1'b0;
                        dm_n    = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            S_EOP_J: begin
                if (bit_end) begin
                    state_n = S_IDLE;
                    oe_n    = 1'b0;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ls_usb_tx.sv
// Self-checking bench for ls_usb_tx: directed vector table, hand-written
// reset / start-while-busy sequences, and random packets against a
// bit-level reference model (bit list -> stuffing -> NRZI -> EOP).
module tb_ls_usb_tx;
    localparam int unsigned CPB  = 8;
    localparam int          MAXC = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sbyte;
    logic       start_pkt;
    logic       last_pkt_byte;
    logic       show_next;
    logic       dp, dm, oe, busy;

    always #5 clk = ~clk;

    ls_usb_tx #(.CLK_PER_BIT(CPB), .TURNAROUND_BITS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .sbyte        (sbyte),
        .start_pkt    (start_pkt),
        .last_pkt_byte(last_pkt_byte),
        .show_next    (show_next),
        .dp           (dp),
        .dm           (dm),
        .oe           (oe),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt [0:7];
    int         pkt_n;

    string      r_wave;
    int         r_oe_len, r_shows, r_first, r_timeout;
    logic [3:0] r_final;

`ifdef LS_TX_TURNAROUND_EN
    localparam int EXP_FIRST = 2 * CPB;
`else
    localparam int EXP_FIRST = 0;
`endif

    typedef struct {
        int          n;
        logic [31:0] bytes;
        string       wave;
        int          shows;
    } vec_t;

    vec_t vecs [0:3];

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    // Expected line states per bit period, straight from the USB rules.
    function automatic string model_wave();
        logic  q[$];
        int    run = 0;
        logic  lvl = 1'b0;
        string w = "";
        logic  b;
        for (int i = 0; i < pkt_n; i++) begin
            for (int j = 0; j < 8; j++) begin
                b = pkt[i][j];
                q.push_back(b);
                run = b ? run + 1 : 0;
                if (run == 6) begin
                    q.push_back(1'b0);
                    run = 0;
                end
            end
        end
        foreach (q[k]) begin
            if (!q[k]) lvl = ~lvl;
            if (lvl) w = {w, "K"};
            else     w = {w, "J"};
        end
        w = {w, "SSJ"};
        return w;
    endfunction

    // Send pkt[0..pkt_n-1], acting as the byte core; inj>=0 pulses a stray start_pkt.
    task automatic run_pkt(input int inj);
        logic [1:0] sym [0:MAXC-1];
        logic       oe_t [0:MAXC-1];
        int         ptr, cyc, last_c, pos;
        bit         seen, done;
        ptr = 0; cyc = 0; seen = 0; done = 0; last_c = 0;
        r_shows = 0; r_oe_len = 0; r_first = -1; r_wave = ""; r_timeout = 0;
        r_final = 4'hx;
        @(negedge clk);
        sbyte = pkt[0];
        last_pkt_byte = (pkt_n == 1);
        start_pkt = 1'b1;
        while (!done && cyc < MAXC) begin
            @(negedge clk);
            sym[cyc]  = {dp, dm};
            oe_t[cyc] = oe;
            if (show_next) begin
                r_shows++;
                ptr++;
                if (ptr < pkt_n) begin
                    sbyte = pkt[ptr];
                    last_pkt_byte = (ptr == pkt_n - 1);
                end
            end
            start_pkt = (cyc == inj);
            if (oe) begin
                if (!seen) r_first = cyc;
                seen = 1;
                r_oe_len++;
            end else if (seen) begin
                done = 1;
                r_final = {dp, dm, oe, busy};
            end
            last_c = cyc;
            cyc++;
        end
        start_pkt = 1'b0;
        if (!done) r_timeout = 1;
        if (r_first >= 0) begin
            pos = r_first + CPB / 2;
            while (pos <= last_c && oe_t[pos]) begin
                case (sym[pos])
                    2'b01:   r_wave = {r_wave, "J"};
                    2'b10:   r_wave = {r_wave, "K"};
                    2'b00:   r_wave = {r_wave, "S"};
                    default: r_wave = {r_wave, "?"};
                endcase
                pos += CPB;
            end
        end
    endtask

    task automatic check_run(input string name, input string exp_wave, input int exp_shows);
        chk_int({name, " timeout"}, r_timeout, 0);
        chk_str({name, " wave"}, r_wave, exp_wave);
        chk_int({name, " oe_cycles"}, r_oe_len, exp_wave.len() * CPB);
        chk_int({name, " show_next"}, r_shows, exp_shows);
        chk_int({name, " first_oe"}, r_first, EXP_FIRST);
        chk_int({name, " end_state"}, int'(r_final), 4);
    endtask

    task automatic load(input int n, input logic [31:0] bytes);
        pkt_n = n;
        for (int i = 0; i < n; i++) pkt[i] = bytes[8*i +: 8];
    endtask

    initial begin
        string ref_wave;
        int    ptr;

        vecs[0].n = 2; vecs[0].bytes = 32'h0000_D280;
        vecs[0].wave = "KJKJKJKKJJKJJKKKSSJ"; vecs[0].shows = 1;
        vecs[1].n = 3; vecs[1].bytes = 32'h00FF_FF80;
        vecs[1].wave = "KJKJKJKKKKKKKJJJJJJJKKKKKKSSJ"; vecs[1].shows = 2;
        vecs[2].n = 2; vecs[2].bytes = 32'h0000_FC80;
        vecs[2].wave = "KJKJKJKKJKKKKKKKJSSJ"; vecs[2].shows = 1;
        vecs[3].n = 1; vecs[3].bytes = 32'h0000_0080;
        vecs[3].wave = "KJKJKJKKSSJ"; vecs[3].shows = 0;

        rst = 1'b1; start_pkt = 1'b0; sbyte = 8'h00; last_pkt_byte = 1'b0;
        repeat (3) @(negedge clk);
        chk_int("reset dp_dm_oe_busy_shownext", int'({dp, dm, oe, busy, show_next}), 8);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            load(vecs[v].n, vecs[v].bytes);
            run_pkt(-1);
            check_run($sformatf("vec%0d", v), vecs[v].wave, vecs[v].shows);
            repeat (3) @(negedge clk);
        end

        // Reset during the 3rd bit of byte 1.
        load(2, 32'h0000_D280);
        @(negedge clk);
        sbyte = pkt[0]; last_pkt_byte = 1'b0; start_pkt = 1'b1;
        ptr = 0;
        for (int c = 0; c < 10 * int'(CPB) + 3; c++) begin
            @(negedge clk);
            start_pkt = 1'b0;
            if (show_next) begin
                ptr++;
                sbyte = pkt[1]; last_pkt_byte = 1'b1;
            end
        end
        chk_int("pre_reset busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_int("mid_reset dp_dm_oe_busy_shownext", int'({dp, dm, oe, busy, show_next}), 8);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_pkt(-1);
        check_run("after_reset", vecs[0].wave, 1);

        // start_pkt while busy must not disturb the waveform.
        load(3, 32'h00FF_FF80);
        run_pkt(5 * CPB + 3);
        check_run("start_while_busy", vecs[1].wave, 2);
        repeat (2) @(negedge clk);

        // Random packets against the model.
        for (int t = 0; t < 20; t++) begin
            pkt_n = 1 + int'($urandom_range(0, 4));
            pkt[0] = 8'h80;
            for (int i = 1; i < pkt_n; i++)
                pkt[i] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            ref_wave = model_wave();
            run_pkt(($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 60)) : -1);
            check_run($sformatf("rand%0d", t), ref_wave, pkt_n - 1);
            repeat (int'($urandom_range(1, 4))) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
